buffer_scheduler: RTL and testbench
===================================

Name: buffer_scheduler

Overview:
- Controller for the shared row buffer: arbitrates the single buffer write port between two requesters (port 0: DMA loader, port 1: PE writeback) with round-robin.
- Sequences tile reads out of the buffer to a downstream consumer over a valid/ready stream.
- Keeps a per-entry valid scoreboard so reads never return unwritten rows and writes never overwrite unconsumed rows.
- Sits between the loaders/PE array and the buffer instance; it owns all buffer address and enable lines.

Parameters:
- WIDTH, 384, row width in bits
- DEPTH, 16, number of buffer entries
- ADDR_W, $clog2(DEPTH), internal address width; all address ports are `ADDR_W wide and only the low ADDR_W bits are used

Ports:
- i_clk  in  1  clock; one clock domain only
- i_rst  in  1  reset; synchronous and active-high
- i_wr_valid  in  2  write request per port [0]=DMA, [1]=PE
- i_wr_addr0  in  `ADDR_W  port 0 target entry
- i_wr_addr1  in  `ADDR_W  port 1 target entry
- i_wr_data0  in  WIDTH  port 0 data
- i_wr_data1  in  WIDTH  port 1 data
- o_wr_ready  out  2  grant per port; a write completes on valid&ready
- o_buf_we  out  1  buffer write enable (combinational)
- o_buf_addr_wr  out  `ADDR_W  buffer write address
- o_buf_data_wr  out  WIDTH  buffer write data
- o_buf_addr_rd  out  `ADDR_W  buffer read address
- i_buf_data_rd  in  WIDTH  buffer read data (combinational from buffer)
- i_rd_start  in  1  start a read tile (pulse)
- i_rd_base  in  `ADDR_W  first entry of the tile
- i_rd_len  in  `ADDR_W+1  row count, 0..DEPTH
- o_rd_valid  out  1  row available to the consumer
- i_rd_ready  in  1  consumer accepts the row
- o_rd_data  out  WIDTH  = i_buf_data_rd
- o_rd_busy  out  1  read sequencer active
- o_rd_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (i_rst high at a clock edge): all scoreboard bits 0, FSM IDLE, rr pointer = 1 (port 0 wins first). All outputs 0, except o_buf_addr_rd = 0 and o_rd_data, which follows the buffer.
- A reset mid-tile aborts the tile; no o_rd_done is issued.
- Eligibility: port p is eligible when i_wr_valid[p] is high and valid[addr_p] == 0.
- Arbitration:
  - Only one eligible port: that port is granted.
  - Both eligible: the port ≠ rr pointer is granted.
  - The pointer updates to the granted port on each grant.
  - o_wr_ready is combinational from the current-cycle state; at most one bit is high.
- On a grant: o_buf_we=1 and the address/data are muxed from the granted port, all combinational. valid[addr] is set on the same edge the buffer captures the data, so a read in the next cycle sees the data.
- Write-write to the same entry: the second write stalls until that entry is consumed.
- FSM:
  - IDLE: i_rd_start with len>0 latches base and len, then goes to RUN. With len==0 it goes to DONE. o_rd_busy=0.
  - RUN: o_buf_addr_rd = ptr and o_rd_valid = valid[ptr]. On o_rd_valid & i_rd_ready: clear valid[ptr], ptr = (ptr+1) mod DEPTH, cnt++. After accepting the row with cnt == len-1, go to DONE.
  - DONE: o_rd_done=1 for one cycle, then IDLE. o_rd_busy is high in RUN and DONE.
  - i_rd_start outside IDLE is ignored.
- Same-cycle read-consume and write to the same entry: the write is not eligible that cycle (bit still set). The bit clears at the edge and the write is granted on the next cycle.
- The pointer wraps from DEPTH-1 to 0. len == DEPTH reads every entry once.
- o_rd_valid must not drop once asserted without acceptance; this holds because only consumption clears bits.

Decomposition:
- Shared package/define file: `ADDR_W, the FSM state encodings (IDLE=0, RUN=1, DONE=2), and the port index constants PORT_DMA=0 and PORT_PE=1.
- One sub-module: rr_arbiter2 (2-way round-robin with eligibility inputs, grant outputs and a pointer register).
- Scoreboard, read FSM and muxes stay in buffer_scheduler.

Test Plan:
- Reset, then port 0 writes entry 3 = 0xA5. Expect o_wr_ready=01 and o_buf_we=1 in the same cycle, with valid[3] set next cycle. Then start base=3, len=1 with i_rd_ready=1: o_rd_valid next cycle with data 0xA5, and o_rd_done one cycle after acceptance.
- Both ports valid continuously to distinct free entries 0..7. Grants alternate 0,1,0,1 starting with port 0, and no cycle has both ready bits high.
- Start base=14, len=4 with rows written in order 15,14,0,1. The consumer receives rows in order 14,15,0,1; o_rd_valid stays low until row 14 exists; pointer wraps.
- Port 1 writes entry 5 while valid[5]=1. Ready stays 0 until the reader consumes 5 (accept edge), then is granted on the following cycle with the new data.
- Consumer holds i_rd_ready=0 for 3 cycles mid-tile. o_rd_valid and data stay stable and no scoreboard bit clears. len=0 start gives o_rd_done one cycle later with no o_rd_valid.
- Assert i_rst during RUN with 2 of 4 rows read. Next cycle: all outputs 0, no o_rd_done, a read from a previously written entry stalls, and a new start works.

Source files
------------

// File: rtl/buffer_scheduler_pkg.sv
// Shared types and constants for the row-buffer scheduler.
package buffer_scheduler_pkg;

    localparam int unsigned DEF_WIDTH  = 384;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned BUF_ADDR_W = $clog2(DEF_DEPTH);

    localparam int unsigned PORT_DMA = 0;
    localparam int unsigned PORT_PE  = 1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_RUN  = 2'd1,
        RD_DONE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on contention the port that did not win last is granted.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    // Holds the index of the most recently granted port.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        unique case (elig_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/buffer_scheduler.sv
// Row-buffer controller: write-port arbitration, per-entry valid scoreboard
// and a tile read sequencer feeding a valid/ready consumer.
module buffer_scheduler
    import buffer_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr0,
    input  logic [ADDR_W-1:0] i_wr_addr1,
    input  logic [WIDTH-1:0]  i_wr_data0,
    input  logic [WIDTH-1:0]  i_wr_data1,
    output logic [1:0]        o_wr_ready,
    output logic              o_buf_we,
    output logic [ADDR_W-1:0] o_buf_addr_wr,
    output logic [WIDTH-1:0]  o_buf_data_wr,
    output logic [ADDR_W-1:0] o_buf_addr_rd,
    input  logic [WIDTH-1:0]  i_buf_data_rd,
    input  logic              i_rd_start,
    input  logic [ADDR_W-1:0] i_rd_base,
    input  logic [ADDR_W:0]   i_rd_len,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_busy,
    output logic              o_rd_done
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    rd_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              rd_acc;
    logic [ADDR_W-1:0] ptr_nxt;

    // A write is only eligible into an entry that has been consumed.
    always_comb begin
        elig[PORT_DMA] = i_wr_valid[PORT_DMA] & ~valid_q[i_wr_addr0];
        elig[PORT_PE]  = i_wr_valid[PORT_PE]  & ~valid_q[i_wr_addr1];
    end

    rr_arbiter2 u_arb (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .elig_i (elig),
        .gnt_o  (gnt)
    );

    always_comb begin
        o_wr_ready    = gnt;
        o_buf_we      = |gnt;
        o_buf_addr_wr = '0;
        o_buf_data_wr = '0;
        if (gnt[PORT_PE]) begin
            o_buf_addr_wr = i_wr_addr1;
            o_buf_data_wr = i_wr_data1;
        end else if (gnt[PORT_DMA]) begin
            o_buf_addr_wr = i_wr_addr0;
            o_buf_data_wr = i_wr_data0;
        end
    end

    always_comb begin
        o_rd_valid    = (state_q == RD_RUN) & valid_q[ptr_q];
        o_buf_addr_rd = (state_q == RD_RUN) ? ptr_q : '0;
        o_rd_data     = i_buf_data_rd;
        o_rd_busy     = (state_q != RD_IDLE);
        o_rd_done     = (state_q == RD_DONE);
        rd_acc        = o_rd_valid & i_rd_ready;
        ptr_nxt       = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
    end

    // Set and clear never hit the same entry: a set entry is never eligible for writing.
    always_comb begin
        valid_d = valid_q;
        if (o_buf_we) begin
            valid_d[o_buf_addr_wr] = 1'b1;
        end
        if (rd_acc) begin
            valid_d[ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RD_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            unique case (state_q)
                RD_IDLE: begin
                    if (i_rd_start) begin
                        if (i_rd_len != '0) begin
                            ptr_q   <= i_rd_base;
                            len_q   <= i_rd_len;
                            cnt_q   <= '0;
                            state_q <= RD_RUN;
                        end else begin
                            state_q <= RD_DONE;
                        end
                    end
                end
                RD_RUN: begin
                    if (rd_acc) begin
                        ptr_q <= ptr_nxt;
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_q <= RD_DONE;
                        end
                    end
                end
                RD_DONE: state_q <= RD_IDLE;
                default: state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_scheduler.sv
// Bench for buffer_scheduler: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_buffer_scheduler;

    localparam int W  = 384;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_valid;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [W-1:0]  wr_data0, wr_data1;
    logic [1:0]    wr_ready;
    logic          buf_we;
    logic [AW-1:0] buf_addr_wr, buf_addr_rd;
    logic [W-1:0]  buf_data_wr, buf_data_rd;
    logic          rd_start;
    logic [AW-1:0] rd_base;
    logic [AW:0]   rd_len;
    logic          rd_valid, rd_ready, rd_busy, rd_done;
    logic [W-1:0]  rd_data;

    always #5 clk = ~clk;

    buffer_scheduler #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(wr_valid), .i_wr_addr0(wr_addr0), .i_wr_addr1(wr_addr1),
        .i_wr_data0(wr_data0), .i_wr_data1(wr_data1), .o_wr_ready(wr_ready),
        .o_buf_we(buf_we), .o_buf_addr_wr(buf_addr_wr), .o_buf_data_wr(buf_data_wr),
        .o_buf_addr_rd(buf_addr_rd), .i_buf_data_rd(buf_data_rd),
        .i_rd_start(rd_start), .i_rd_base(rd_base), .i_rd_len(rd_len),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_rd_busy(rd_busy), .o_rd_done(rd_done)
    );

    // Buffer instance stand-in: synchronous write, combinational read.
    logic [W-1:0] bufmem [D];
    always @(posedge clk) if (buf_we) bufmem[buf_addr_wr] <= buf_data_wr;
    assign buf_data_rd = bufmem[buf_addr_rd];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: scoreboard bits, shadow memory, last winner, and the tile
    // as a queue of entries still to be delivered.
    bit           m_sb [D];
    logic [W-1:0] m_mem [D];
    bit           m_last = 1'b1;
    int           m_phase = 0;  // 0 idle, 1 delivering, 2 done pulse
    int           m_q [$];

    logic [1:0]    e_ready;
    logic          e_we, e_rvalid, e_done, e_busy;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [W-1:0]  e_wdata, e_rdata;

    task automatic model_eval();
        bit el0, el1;
        el0 = wr_valid[0] && !m_sb[wr_addr0];
        el1 = wr_valid[1] && !m_sb[wr_addr1];
        if (el0 && el1) e_ready = m_last ? 2'b01 : 2'b10;
        else            e_ready = {el1, el0};
        e_we     = |e_ready;
        e_waddr  = e_ready[1] ? wr_addr1 : wr_addr0;
        e_wdata  = e_ready[1] ? wr_data1 : wr_data0;
        e_rvalid = (m_phase == 1) && m_sb[m_q[0]];
        e_raddr  = (m_phase == 1) ? AW'(m_q[0]) : '0;
        e_rdata  = e_rvalid ? m_mem[m_q[0]] : '0;
        e_done   = (m_phase == 2);
        e_busy   = (m_phase != 0);
    endtask

    task automatic model_check();
        chk("wr_ready", W'(wr_ready), W'(e_ready));
        chk("buf_we", W'(buf_we), W'(e_we));
        if (e_we) begin
            chk("buf_addr_wr", W'(buf_addr_wr), W'(e_waddr));
            chk("buf_data_wr", buf_data_wr, e_wdata);
        end
        chk("rd_valid", W'(rd_valid), W'(e_rvalid));
        chk("rd_busy", W'(rd_busy), W'(e_busy));
        chk("rd_done", W'(rd_done), W'(e_done));
        if (m_phase == 1) chk("buf_addr_rd", W'(buf_addr_rd), W'(e_raddr));
        if (e_rvalid) chk("rd_data", rd_data, e_rdata);
    endtask

    task automatic model_update();
        if (rst) begin
            foreach (m_sb[i]) m_sb[i] = 1'b0;
            m_last  = 1'b1;
            m_phase = 0;
            m_q.delete();
        end else begin
            if (e_we) begin
                m_sb[e_waddr]  = 1'b1;
                m_mem[e_waddr] = e_wdata;
                m_last         = e_ready[1];
            end
            case (m_phase)
                0: if (rd_start) begin
                    if (rd_len == '0) m_phase = 2;
                    else begin
                        for (int i = 0; i < int'(rd_len); i++) m_q.push_back((int'(rd_base) + i) % D);
                        m_phase = 1;
                    end
                end
                1: if (e_rvalid && rd_ready) begin
                    m_sb[m_q[0]] = 1'b0;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic settle(); #1; model_eval(); model_check(); endtask
    task automatic adv();    model_update(); @(negedge clk); endtask
    task automatic cyc();    settle(); adv(); endtask

    task automatic idle_in();
        rst = 1'b0; wr_valid = 2'b00; wr_addr0 = '0; wr_addr1 = '0;
        wr_data0 = '0; wr_data1 = '0; rd_start = 1'b0; rd_base = '0;
        rd_len = '0; rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_in(); rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic wr0(input int a, input logic [W-1:0] d);
        wr_valid[0] = 1'b1; wr_addr0 = AW'(a); wr_data0 = d;
    endtask

    task automatic start(input int base, input int len);
        rd_start = 1'b1; rd_base = AW'(base); rd_len = (AW+1)'(len);
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    typedef struct {
        logic       rst;
        logic [1:0] wv;
        int         a0, a1;
        logic [7:0] d0, d1;
        logic       st;
        int         base, len;
        logic       rdy;
        logic [1:0] e_ready;
        logic       e_we;
        int         e_waddr;
        logic       e_rvalid;
        logic [7:0] e_rdata;
        logic       e_done, e_busy;
    } vec_t;

    vec_t vt [$];
    logic [7:0] got [$];
    logic [W-1:0] held;
    bit seen_done;

    initial begin
        // rst wv  a0 a1 d0     d1     st base len rdy | ready we wa rv rdata  done busy
        vt.push_back('{0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b01, 3, 0, 8'hA5, 8'h00, 0, 0, 0, 0, 2'b01, 1, 3, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b00, 0, 0, 8'h00, 8'h00, 1, 3, 1, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 0, 0, 1, 8'hA5, 0, 1});
        vt.push_back('{0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 8'h00, 1, 1});
        vt.push_back('{0, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0});
        vt.push_back('{1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 0, 1, 8'h10, 8'h11, 0, 0, 0, 0, 2'b01, 1, 0, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 2, 1, 8'h12, 8'h11, 0, 0, 0, 0, 2'b10, 1, 1, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 2, 3, 8'h12, 8'h13, 0, 0, 0, 0, 2'b01, 1, 2, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 4, 3, 8'h14, 8'h13, 0, 0, 0, 0, 2'b10, 1, 3, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 4, 5, 8'h14, 8'h15, 0, 0, 0, 0, 2'b01, 1, 4, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 6, 5, 8'h16, 8'h15, 0, 0, 0, 0, 2'b10, 1, 5, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 6, 7, 8'h16, 8'h17, 0, 0, 0, 0, 2'b01, 1, 6, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b10, 6, 7, 8'h16, 8'h17, 0, 0, 0, 0, 2'b10, 1, 7, 0, 8'h00, 0, 0});
        vt.push_back('{0, 2'b11, 0, 1, 8'h20, 8'h21, 0, 0, 0, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0});

        idle_in();
        rst = 1'b1;
        @(negedge clk);
        adv();
        rst = 1'b0;

        // Vector table: reset state, first write/read, alternating arbitration.
        foreach (vt[i]) begin
            rst = vt[i].rst; wr_valid = vt[i].wv;
            wr_addr0 = AW'(vt[i].a0); wr_addr1 = AW'(vt[i].a1);
            wr_data0 = W'(vt[i].d0); wr_data1 = W'(vt[i].d1);
            rd_start = vt[i].st; rd_base = AW'(vt[i].base);
            rd_len = (AW+1)'(vt[i].len); rd_ready = vt[i].rdy;
            settle();
            chk($sformatf("vec%0d_ready", i), W'(wr_ready), W'(vt[i].e_ready));
            chk($sformatf("vec%0d_we", i), W'(buf_we), W'(vt[i].e_we));
            if (vt[i].e_we) chk($sformatf("vec%0d_waddr", i), W'(buf_addr_wr), W'(vt[i].e_waddr));
            chk($sformatf("vec%0d_rvalid", i), W'(rd_valid), W'(vt[i].e_rvalid));
            if (vt[i].e_rvalid) chk($sformatf("vec%0d_rdata", i), rd_data, W'(vt[i].e_rdata));
            chk($sformatf("vec%0d_done", i), W'(rd_done), W'(vt[i].e_done));
            chk($sformatf("vec%0d_busy", i), W'(rd_busy), W'(vt[i].e_busy));
            adv();
        end

        // Wrapping tile 14,15,0,1 with rows arriving out of order.
        do_reset();
        idle_in(); start(14, 4); rd_ready = 1'b1; cyc();
        got.delete(); seen_done = 0;
        for (int k = 0; k < 14; k++) begin
            idle_in(); rd_ready = 1'b1;
            case (k)
                2: wr0(15, W'(8'h4F));
                3: wr0(14, W'(8'h4E));
                4: wr0(0, W'(8'h40));
                5: wr0(1, W'(8'h41));
                default: ;
            endcase
            settle();
            if (k <= 3) chk("wrap_wait_valid", W'(rd_valid), W'(0));
            if (rd_valid && rd_ready) got.push_back(rd_data[7:0]);
            if (rd_done) seen_done = 1;
            adv();
        end
        chk("wrap_rows", W'(got.size()), W'(4));
        if (got.size() == 4) begin
            chk("wrap_row0", W'(got[0]), W'(8'h4E));
            chk("wrap_row1", W'(got[1]), W'(8'h4F));
            chk("wrap_row2", W'(got[2]), W'(8'h40));
            chk("wrap_row3", W'(got[3]), W'(8'h41));
        end
        chk("wrap_done", W'(seen_done), W'(1));

        // Port 1 writes into an unconsumed entry and stalls until it is read.
        do_reset();
        idle_in(); wr0(5, W'(8'h55)); cyc();
        idle_in(); wr_valid = 2'b10; wr_addr1 = 4'd5; wr_data1 = W'(8'h66);
        for (int k = 0; k < 3; k++) begin
            settle(); chk("ovw_stall", W'(wr_ready), W'(2'b00)); adv();
        end
        start(5, 1); rd_ready = 1'b1; cyc();
        rd_start = 1'b0;
        settle();
        chk("ovw_accept_valid", W'(rd_valid), W'(1));
        chk("ovw_accept_ready", W'(wr_ready), W'(2'b00));
        adv();
        settle(); chk("ovw_grant", W'(wr_ready), W'(2'b10)); adv();
        idle_in(); cyc();
        start(5, 1); rd_ready = 1'b1; cyc();
        rd_start = 1'b0;
        settle();
        chk("ovw_new_valid", W'(rd_valid), W'(1));
        chk("ovw_new_data", rd_data, W'(8'h66));
        adv();
        cyc();

        // Consumer back-pressure mid-tile, then a zero-length tile.
        do_reset();
        for (int i = 0; i < 4; i++) begin idle_in(); wr0(i, W'(8'h30 + i)); cyc(); end
        idle_in(); start(0, 4); rd_ready = 1'b1; cyc();
        rd_start = 1'b0; cyc();
        rd_ready = 1'b0;
        settle(); held = rd_data; adv();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("stall_valid", W'(rd_valid), W'(1));
            chk("stall_data", rd_data, W'(8'h31));
            chk("stall_hold", rd_data, held);
            adv();
        end
        rd_ready = 1'b1; seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            settle(); if (rd_done) seen_done = 1; adv();
        end
        chk("stall_done", W'(seen_done), W'(1));
        idle_in(); start(0, 0); cyc();
        idle_in();
        settle();
        chk("len0_done", W'(rd_done), W'(1));
        chk("len0_valid", W'(rd_valid), W'(0));
        adv();

        // Reset in the middle of a tile.
        do_reset();
        for (int i = 0; i < 4; i++) begin idle_in(); wr0(i, W'(8'h50 + i)); cyc(); end
        idle_in(); start(0, 4); rd_ready = 1'b1; cyc();
        rd_start = 1'b0; cyc(); cyc();
        rd_ready = 1'b0; rst = 1'b1; cyc(); rst = 1'b0;
        settle();
        chk("mrst_ready", W'(wr_ready), W'(0));
        chk("mrst_we", W'(buf_we), W'(0));
        chk("mrst_addr_wr", W'(buf_addr_wr), W'(0));
        chk("mrst_data_wr", buf_data_wr, W'(0));
        chk("mrst_addr_rd", W'(buf_addr_rd), W'(0));
        chk("mrst_valid", W'(rd_valid), W'(0));
        chk("mrst_busy", W'(rd_busy), W'(0));
        chk("mrst_done", W'(rd_done), W'(0));
        adv();
        start(2, 1); rd_ready = 1'b1; cyc();
        rd_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("mrst_stale_valid", W'(rd_valid), W'(0));
            chk("mrst_busy_run", W'(rd_busy), W'(1));
            adv();
        end
        wr0(2, W'(8'h77)); cyc();
        idle_in(); rd_ready = 1'b1;
        settle();
        chk("mrst_new_valid", W'(rd_valid), W'(1));
        chk("mrst_new_data", rd_data, W'(8'h77));
        adv();
        settle(); chk("mrst_new_done", W'(rd_done), W'(1)); adv();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            wr_valid = 2'($urandom_range(0, 3));
            wr_addr0 = AW'($urandom_range(0, D - 1));
            wr_addr1 = AW'($urandom_range(0, D - 1));
            wr_data0 = rnd_data();
            wr_data1 = rnd_data();
            rd_start = ($urandom_range(0, 5) == 0);
            rd_base  = AW'($urandom_range(0, D - 1));
            rd_len   = (AW+1)'($urandom_range(0, D));
            rd_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
